// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-mapped slave controller.
package mem_pkg;

  localparam int unsigned AddrWDefault = 6;
  localparam int unsigned DataWDefault = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2
  } phase_e;

  function automatic logic in_prot(int unsigned addr, int unsigned lo, int unsigned hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/mem_slave_ctrl_if.sv
// Command/response bundle between the stimulus generator and mem_slave_ctrl.
interface mem_slave_ctrl_if
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = 16
);

  logic              en;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              wr_err;
  logic              dir_chg;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [1:0]        state_o;

  modport master (
    output en, wr, addr, wdata,
    input  rdata, rvalid, wr_err, dir_chg, wr_cnt, rd_cnt, state_o
  );

  modport slave (
    input  en, wr, addr, wdata,
    output rdata, rvalid, wr_err, dir_chg, wr_cnt, rd_cnt, state_o
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_slave_ctrl.sv
// Register-array slave: 1-cycle read latency, write-protected window,
// saturating access counters and a read/write phase tracker.
module mem_slave_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = AddrWDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PROT_LO = 48,
  parameter int unsigned PROT_HI = 63
) (
  input logic             clk,
  input logic             rst_n,
  mem_slave_ctrl_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wr_err_q, wr_err_d;
  logic              dir_chg_q, dir_chg_d;
  phase_e            state_q, state_d;

  logic wr_cmd, rd_cmd, prot_hit, wr_acc;

  assign wr_cmd   = bus.en & bus.wr;
  assign rd_cmd   = bus.en & ~bus.wr;
  assign prot_hit = in_prot(32'(bus.addr), PROT_LO, PROT_HI);
  assign wr_acc   = wr_cmd & ~prot_hit;

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) begin
      mem_d[bus.addr] = bus.wdata;
    end
  end

  // Read and write are exclusive per cycle, so reading mem_q needs no bypass.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_cmd;
    wr_err_d = wr_cmd & prot_hit;
    if (rd_cmd) begin
      rdata_d = mem_q[bus.addr];
    end
  end

  // Rejected writes still count as a write phase.
  always_comb begin
    state_d   = state_q;
    dir_chg_d = 1'b0;
    if (!bus.en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  state_d = bus.wr ? StWrite : StRead;
        StWrite: begin
          if (!bus.wr) begin
            state_d   = StRead;
            dir_chg_d = 1'b1;
          end
        end
        StRead:  begin
          if (bus.wr) begin
            state_d   = StWrite;
            dir_chg_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      dir_chg_q <= 1'b0;
      state_q   <= StIdle;
    end else begin
      mem_q     <= mem_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      wr_err_q  <= wr_err_d;
      dir_chg_q <= dir_chg_d;
      state_q   <= state_d;
    end
  end

  sat_counter #(
    .Width(CNT_W)
  ) u_wr_cnt (
    .clk_i (clk),
    .rst_ni(rst_n),
    .inc_i (wr_acc),
    .cnt_o (bus.wr_cnt)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_rd_cnt (
    .clk_i (clk),
    .rst_ni(rst_n),
    .inc_i (rd_cmd),
    .cnt_o (bus.rd_cnt)
  );

  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.wr_err  = wr_err_q;
  assign bus.dir_chg = dir_chg_q;
  assign bus.state_o = state_q;

endmodule
